// File: rtl/frame_pkg.sv
// Shared types and widths for the serial frame deserializer.
package frame_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

endpackage

// File: rtl/frame_deserializer.sv
// Serial frame deserializer: start bit 0, 8 data bits LSB first,
// optional even-parity bit, stop bit 1. Cycles with sin_valid=0 stall.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for a qualified start bit (sin=0)
// DATA   | collecting data bits into shreg, bit_cnt = next bit index
// PARITY | capturing the parity bit (only reached when PARITY_EN=1)
// STOP   | checking the stop bit, then publishing data or flagging error
module frame_deserializer
  import frame_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] data,
  output logic              enable,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err
);

  state_e                 state_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0]      shreg_q;
  logic                   par_q;
  logic [DATA_W-1:0]      data_q;
  logic                   enable_q;
  logic                   parity_err_q;
  logic                   frame_err_q;
  logic                   parity_ok;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok = PARITY_EN ? ~(^{shreg_q, par_q}) : 1'b1;

  // FSM, shift register and registered strobes. Strobes self-clear every
  // cycle so they last exactly one cycle even if the next cycle stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      data_q       <= '0;
      enable_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      enable_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (sin_valid) begin
        unique case (state_q)
          IDLE: begin
            if (!sin) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shreg_q[bit_cnt_q] <= sin;
            // Hold the counter at the last index rather than wrapping.
            if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
              state_q <= PARITY_EN ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          PARITY: begin
            par_q   <= sin;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!sin) begin
              frame_err_q <= 1'b1;
            end else if (!parity_ok) begin
              parity_err_q <= 1'b1;
            end else begin
              data_q   <= shreg_q;
              enable_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data       = data_q;
  assign enable     = enable_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench for frame_deserializer: a table of whole frames plus
// hand-written sequences for stalls, back-to-back frames, reset mid-frame
// and an idle line.
module tb_frame_deserializer;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic [7:0] data;
  logic       enable;
  logic       busy;
  logic       parity_err;
  logic       frame_err;

  int n_vec  = 0;
  int n_fail = 0;

  int en_cnt     = 0;
  int pe_cnt     = 0;
  int fe_cnt     = 0;
  int busy_hi    = 0;
  int busy_drop  = 0;
  int excl_cnt   = 0;
  bit mon_busy   = 1'b0;

  frame_deserializer #(.PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .data       (data),
    .enable     (enable),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitors sampled on the falling edge.
  always @(negedge clk) begin
    en_cnt  += int'(enable);
    pe_cnt  += int'(parity_err);
    fe_cnt  += int'(frame_err);
    busy_hi += int'(busy);
    if (mon_busy && !busy) busy_drop++;
    if ((int'(enable) + int'(parity_err) + int'(frame_err)) > 1) excl_cnt++;
  end

  typedef struct {
    logic [7:0] d;
    bit         par;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_en;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One qualified bit, then 'gap' stalled cycles with a random line value.
  task automatic send_bit(input bit b, input int gap);
    sin       = b;
    sin_valid = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < gap; g++) begin
      sin_valid = 1'b0;
      sin       = 1'($urandom);
      @(posedge clk); #1;
    end
    sin_valid = 1'b0;
  endtask

  // Full frame; returns #1 after the stop-bit sample edge.
  task automatic send_frame(input logic [7:0] d, input bit par, input bit stop,
                            input int maxgap);
    send_bit(1'b0, $urandom_range(maxgap, 0));
    mon_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(maxgap, 0));
    send_bit(par, $urandom_range(maxgap, 0));
    mon_busy = 1'b0;
    send_bit(stop, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sin       = 1'b1;
      sin_valid = 1'b1;
      @(posedge clk); #1;
    end
    sin_valid = 1'b0;
  endtask

  int e0, p0, f0, b0, d0;

  initial begin
    //          d      par   stop  exp_data en pe fe
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1, 0, 0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'hA5, 0, 1, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 0, 0, 1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1, 0, 0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1, 0, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1, 0, 0};
    vecs[6] = '{8'h7F, 1'b0, 1'b0, 8'h80, 0, 0, 1};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 8'h80, 0, 1, 0};
    vecs[8] = '{8'h00, 1'b0, 1'b1, 8'h00, 1, 0, 0};

    rst       = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data", int'(data), 8'h00);
    check("reset enable", int'(enable), 0);
    check("reset busy", int'(busy), 0);
    check("reset parity_err", int'(parity_err), 0);
    check("reset frame_err", int'(frame_err), 0);
    rst = 1'b0;
    idle_cycles(2);

    // Table: one frame per record, line held valid, strobe checked on the
    // cycle right after the stop-bit edge.
    foreach (vecs[i]) begin
      e0 = en_cnt; p0 = pe_cnt; f0 = fe_cnt;
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, 0);
      check($sformatf("vec%0d enable", i), int'(enable), int'(vecs[i].exp_en));
      check($sformatf("vec%0d parity_err", i), int'(parity_err), int'(vecs[i].exp_pe));
      check($sformatf("vec%0d frame_err", i), int'(frame_err), int'(vecs[i].exp_fe));
      check($sformatf("vec%0d busy after stop", i), int'(busy), 0);
      idle_cycles(2);
      check($sformatf("vec%0d data", i), int'(data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d enable pulses", i), en_cnt - e0, int'(vecs[i].exp_en));
      check($sformatf("vec%0d parity_err pulses", i), pe_cnt - p0, int'(vecs[i].exp_pe));
      check($sformatf("vec%0d frame_err pulses", i), fe_cnt - f0, int'(vecs[i].exp_fe));
    end

    // A5 with random stalls of 0-3 cycles; busy must never drop mid-frame.
    e0 = en_cnt; d0 = busy_drop;
    send_frame(8'hA5, 1'b0, 1'b1, 3);
    check("gap enable strobe", int'(enable), 1);
    check("gap data", int'(data), 8'hA5);
    idle_cycles(2);
    check("gap enable pulses", en_cnt - e0, 1);
    check("gap busy held", busy_drop - d0, 0);

    // Bad stop bit immediately followed by a good frame, no idle between.
    e0 = en_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check("b2b frame_err", int'(frame_err), 1);
    check("b2b idle after bad stop", int'(busy), 0);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    check("b2b enable", int'(enable), 1);
    check("b2b data", int'(data), 8'h3C);
    idle_cycles(1);
    check("b2b enable pulses", en_cnt - e0, 1);
    check("b2b frame_err pulses", fe_cnt - f0, 1);

    // Reset after 4 data bits, with sin_valid high during reset.
    e0 = en_cnt; p0 = pe_cnt; f0 = fe_cnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    rst       = 1'b1;
    sin       = 1'b0;
    sin_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    sin_valid = 1'b0;
    check("rst data cleared", int'(data), 8'h00);
    check("rst busy", int'(busy), 0);
    @(posedge clk); #1;
    check("rst no pulses", (en_cnt - e0) + (pe_cnt - p0) + (fe_cnt - f0), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    check("post-rst enable", int'(enable), 1);
    check("post-rst data", int'(data), 8'h5A);
    idle_cycles(2);
    check("post-rst enable pulses", en_cnt - e0, 1);

    // Idle line: sin=1 qualified for 20 cycles.
    e0 = en_cnt; p0 = pe_cnt; f0 = fe_cnt; b0 = busy_hi;
    idle_cycles(20);
    @(negedge clk);
    check("idle busy", busy_hi - b0, 0);
    check("idle pulses", (en_cnt - e0) + (pe_cnt - p0) + (fe_cnt - f0), 0);

    check("strobes exclusive", excl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_deserializer.md
FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: PARITY_EN, default 1, 1 = frame carries an even-parity bit, 0 = no parity bit.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: sin  input  1  serial line bit.
REQ-006 Port: sin_valid  input  1  qualifies sin; sin is sampled only on edges where sin_valid=1.
REQ-007 Port: data  output  8  last correctly received byte, held until the next good frame.
REQ-008 Port: enable  output  1  one-cycle strobe meaning data is new; directly drives the load enable of the downstream 8-bit register.
REQ-009 Port: busy  output  1  high while a frame is in progress (state is not IDLE).
REQ-010 Port: parity_err  output  1  one-cycle pulse when a frame fails the parity check.
REQ-011 Port: frame_err  output  1  one-cycle pulse when a frame has a bad stop bit.

Function
REQ-012 Frame format SHALL be: start bit 0, then 8 data bits LSB first, then one parity bit if PARITY_EN=1, then stop bit 1.
REQ-013 The FSM states SHALL be IDLE, DATA, PARITY, STOP; cycles with sin_valid=0 SHALL leave all state unchanged (stall).
REQ-014 IDLE: a qualified sin=0 SHALL go to DATA with bit_cnt=0; a qualified sin=1 SHALL stay in IDLE.
REQ-015 DATA: each qualified bit SHALL be written to shreg[bit_cnt] and bit_cnt SHALL increment.
REQ-016 DATA: after the qualified bit with bit_cnt=7, the FSM SHALL go to PARITY, or to STOP if PARITY_EN=0.
REQ-017 PARITY: the qualified bit SHALL be captured and the FSM SHALL go to STOP.
REQ-018 Parity SHALL be even: the XOR of the 8 data bits and the parity bit must be 0.
REQ-019 STOP with qualified sin=1 and parity OK: on the same edge, data <= shreg, enable=1 for exactly that following cycle, and the FSM returns to IDLE.
REQ-020 STOP with qualified sin=0: frame_err SHALL pulse for one cycle, data SHALL be unchanged, enable SHALL stay 0, and the FSM returns to IDLE; frame_err takes priority over parity_err.
REQ-021 STOP with qualified sin=1 and a parity mismatch: parity_err SHALL pulse for one cycle, data SHALL be unchanged, enable SHALL stay 0, and the FSM returns to IDLE.
REQ-022 Latency from the stop-bit sample edge to enable high SHALL be 1 cycle.
REQ-023 The first bit of the next frame SHALL be accepted on the cycle immediately after the stop bit, with no dead cycle.
REQ-024 enable, parity_err and frame_err SHALL be registered and mutually exclusive in any cycle.
REQ-025 bit_cnt SHALL be 3 bits and SHALL never wrap within a frame; it is cleared on entry to DATA.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set: state=IDLE, bit_cnt=0, shreg=0, data=8'h00, enable=0, busy=0, parity_err=0, frame_err=0.
REQ-027 Reset mid-frame SHALL discard the partial frame, with no strobe and no error pulse; reset SHALL take priority over sin_valid.

Structure
REQ-028 A shared package frame_pkg SHALL hold the state enum (IDLE, DATA, PARITY, STOP), DATA_W=8, and BIT_CNT_W=3.
REQ-029 The block SHALL have no sub-module: one always_ff for the FSM and shift register, plus a combinational parity reduction.

Verification
REQ-030 Frame for 8'hA5 with parity (bits 0,1,0,1,0,0,1,0,1,0,1), sin_valid held high -> data=8'hA5 and enable high for exactly 1 cycle, 1 cycle after the stop bit.
REQ-031 Same 8'hA5 frame with random sin_valid=0 gaps of 0-3 cycles -> identical data, a single enable pulse, and busy high throughout the frame.
REQ-032 Frame for 8'h01 with parity bit 0 -> parity_err pulses once, enable stays 0, data still 8'hA5.
REQ-033 Frame for 8'h3C with stop bit 0 -> frame_err pulses once, enable stays 0, FSM back in IDLE; an immediately following good 8'h3C frame -> data=8'h3C.
REQ-034 rst asserted after 4 data bits, then a full frame for 8'h5A -> no pulse during reset, data=8'h00 after reset, then data=8'h5A with one enable pulse.
REQ-035 Idle line with sin=1 and sin_valid=1 for 20 cycles -> busy stays 0 and no output pulses.
